// File: rtl/sprite_ram_arbiter.sv
// Sprite RAM port arbiter: one unstalled loader write port plus two round-robin draw read ports
// sharing a synchronous-read RAM, with an in-order two-stage read response pipeline.
module sprite_ram_arbiter #(
   parameter int unsigned AW    = 13,
   parameter int unsigned DEPTH = 6613,
   parameter int unsigned WDW   = 8,
   parameter int unsigned RDW   = 5
) (
   input  logic           Clk,
   input  logic           Reset_n,
   // player-sprite draw reads
   input  logic           rd0_req,
   input  logic [AW-1:0]  rd0_addr,
   output logic           rd0_gnt,
   // NPC/overlay draw reads
   input  logic           rd1_req,
   input  logic [AW-1:0]  rd1_addr,
   output logic           rd1_gnt,
   // sprite loader writes
   input  logic           wr_req,
   input  logic [AW-1:0]  wr_addr,
   input  logic [WDW-1:0] wr_data,
   output logic           wr_gnt,
   // read response
   output logic           rsp_valid,
   output logic           rsp_id,
   output logic           rsp_err,
   output logic [RDW-1:0] rsp_data,
   // RAM side
   output logic [AW-1:0]  ram_read_address,
   output logic [AW-1:0]  ram_write_address,
   output logic [WDW-1:0] ram_data_In,
   output logic           ram_we,
   input  logic [RDW-1:0] ram_data_Out
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic           w_elig0;
   logic           w_elig1;
   logic           w_gnt0;
   logic           w_gnt1;
   logic           w_rd_any;
   logic [AW-1:0]  w_rd_addr;
   logic           w_rd_inr;
   logic           w_wr_inr;

   logic           r_prio1;
   logic           r_we;
   logic [AW-1:0]  r_waddr;
   logic [WDW-1:0] r_wdata;
   logic [AW-1:0]  r_raddr;
   logic           r_s1_valid;
   logic           r_s1_id;
   logic           r_s1_err;
   logic           r_s2_valid;
   logic           r_s2_id;
   logic           r_s2_err;

   // A read matching this cycle's write address would see stale data, so it waits a cycle.
   always_comb begin
      w_elig0   = rd0_req & ~(wr_req & (rd0_addr == wr_addr));
      w_elig1   = rd1_req & ~(wr_req & (rd1_addr == wr_addr));
      w_gnt0    = Reset_n & w_elig0 & (~w_elig1 | ~r_prio1);
      w_gnt1    = Reset_n & w_elig1 & (~w_elig0 | r_prio1);
      w_rd_any  = w_gnt0 | w_gnt1;
      w_rd_addr = w_gnt1 ? rd1_addr : rd0_addr;
      w_rd_inr  = ({1'b0, w_rd_addr} < LP_DEPTH);
      w_wr_inr  = ({1'b0, wr_addr} < LP_DEPTH);
   end

   assign rd0_gnt = w_gnt0;
   assign rd1_gnt = w_gnt1;
   assign wr_gnt  = wr_req;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_prio1    <= 1'b0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_raddr    <= '0;
         r_s1_valid <= 1'b0;
         r_s1_id    <= 1'b0;
         r_s1_err   <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_id    <= 1'b0;
         r_s2_err   <= 1'b0;
      end else begin
         r_we <= wr_req & w_wr_inr;
         if (wr_req && w_wr_inr) begin
            r_waddr <= wr_addr;
            r_wdata <= wr_data;
         end
         // r_prio1 set means rd1 wins the next tie
         if (w_gnt0) begin
            r_prio1 <= 1'b1;
         end else if (w_gnt1) begin
            r_prio1 <= 1'b0;
         end
         if (w_rd_any && w_rd_inr) begin
            r_raddr <= w_rd_addr;
         end
         r_s1_valid <= w_rd_any;
         r_s1_id    <= w_gnt1;
         r_s1_err   <= w_rd_any & ~w_rd_inr;
         r_s2_valid <= r_s1_valid;
         r_s2_id    <= r_s1_id;
         r_s2_err   <= r_s1_err;
      end
   end

   assign ram_we            = r_we;
   assign ram_write_address = r_waddr;
   assign ram_data_In       = r_wdata;
   assign ram_read_address  = r_raddr;

   // RAM output lands in the same cycle as the response, so data is passed through, not flopped.
   always_comb begin
      rsp_valid = r_s2_valid;
      rsp_id    = r_s2_valid & r_s2_id;
      rsp_err   = r_s2_valid & r_s2_err;
      rsp_data  = (r_s2_valid && !r_s2_err) ? ram_data_Out : '0;
   end

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Directed bench for sprite_ram_arbiter with a behavioural synchronous-read sprite RAM.
module tb_sprite_ram_arbiter;

   localparam int unsigned AW    = 13;
   localparam int unsigned DEPTH = 6613;
   localparam int unsigned WDW   = 8;
   localparam int unsigned RDW   = 5;

   logic           Clk;
   logic           Reset_n;
   logic           rd0_req, rd1_req, wr_req;
   logic [AW-1:0]  rd0_addr, rd1_addr, wr_addr;
   logic [WDW-1:0] wr_data;
   logic           rd0_gnt, rd1_gnt, wr_gnt;
   logic           rsp_valid, rsp_id, rsp_err;
   logic [RDW-1:0] rsp_data;
   logic [AW-1:0]  ram_read_address, ram_write_address;
   logic [WDW-1:0] ram_data_In;
   logic           ram_we;
   logic [RDW-1:0] ram_data_Out;

   int n_checks;
   int n_errs;

   logic [WDW-1:0] mem [0:8191];

   sprite_ram_arbiter #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .WDW   (WDW),
      .RDW   (RDW)
   ) dut (
      .Clk               (Clk),
      .Reset_n           (Reset_n),
      .rd0_req           (rd0_req),
      .rd0_addr          (rd0_addr),
      .rd0_gnt           (rd0_gnt),
      .rd1_req           (rd1_req),
      .rd1_addr          (rd1_addr),
      .rd1_gnt           (rd1_gnt),
      .wr_req            (wr_req),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .wr_gnt            (wr_gnt),
      .rsp_valid         (rsp_valid),
      .rsp_id            (rsp_id),
      .rsp_err           (rsp_err),
      .rsp_data          (rsp_data),
      .ram_read_address  (ram_read_address),
      .ram_write_address (ram_write_address),
      .ram_data_In       (ram_data_In),
      .ram_we            (ram_we),
      .ram_data_Out      (ram_data_Out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Contents: mem[a] = a[4:0] ^ 5'h1A, so RAM[0x010] = 0x0A.
   initial begin
      for (int i = 0; i < 8192; i++) begin
         mem[i] = WDW'(i[4:0] ^ 5'h1A);
      end
   end

   always @(posedge Clk) begin
      if (ram_we) mem[ram_write_address] <= ram_data_In;
      ram_data_Out <= mem[ram_read_address][RDW-1:0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rd0_req = 1'b0; rd0_addr = '0;
      rd1_req = 1'b0; rd1_addr = '0;
      wr_req = 1'b0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic nxt();
      @(negedge Clk);
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic id, input logic e,
                          input logic [RDW-1:0] d);
      chk({tag, "_valid"}, rsp_valid, v);
      chk({tag, "_id"}, rsp_id, id);
      chk({tag, "_err"}, rsp_err, e);
      chk({tag, "_data"}, rsp_data, d);
   endtask

   initial begin
      n_checks = 0;
      n_errs   = 0;
      Reset_n  = 1'b0;
      idle();

      // Reset: write and read requests presented while in reset
      nxt();
      rd0_req = 1'b1; rd0_addr = 13'h010;
      wr_req = 1'b1; wr_addr = 13'h005; wr_data = 8'h77;
      #1;
      chk("rst_rd0_gnt", rd0_gnt, 1'b0);
      chk("rst_wr_gnt", wr_gnt, 1'b1);
      nxt(); #1;
      chk("rst_we", ram_we, 1'b0);
      chk("rst_raddr", ram_read_address, 13'h0);
      chk("rst_waddr", ram_write_address, 13'h0);
      chk("rst_wdata", ram_data_In, 8'h0);
      chk_rsp("rst_rsp", 1'b0, 1'b0, 1'b0, 5'h0);
      nxt(); Reset_n = 1'b1; idle(); #1;
      chk("rst_we_after", ram_we, 1'b0);

      // Contention: rd0 favoured first after reset, then alternate
      for (int i = 0; i < 6; i++) begin
         nxt();
         if (i < 4) begin
            rd0_req = 1'b1; rd0_addr = 13'h011;
            rd1_req = 1'b1; rd1_addr = 13'h012;
         end else begin
            idle();
         end
         #1;
         if (i < 4) begin
            chk("cont_g0", rd0_gnt, (i % 2 == 0));
            chk("cont_g1", rd1_gnt, (i % 2 == 1));
         end
         if (i >= 2) begin
            chk_rsp("cont_rsp", 1'b1, (i % 2 == 1), 1'b0, (i % 2 == 1) ? 5'h08 : 5'h0B);
         end
      end
      nxt(); #1;
      chk("cont_rsp_end", rsp_valid, 1'b0);

      // Single read of 0x010
      nxt(); rd0_req = 1'b1; rd0_addr = 13'h010; #1;
      chk("single_g0", rd0_gnt, 1'b1);
      chk("single_g1", rd1_gnt, 1'b0);
      nxt(); idle(); #1;
      chk("single_raddr", ram_read_address, 13'h010);
      chk("single_early", rsp_valid, 1'b0);
      nxt(); #1;
      chk_rsp("single_rsp", 1'b1, 1'b0, 1'b0, 5'h0A);
      nxt(); #1;
      chk_rsp("single_after", 1'b0, 1'b0, 1'b0, 5'h0);
      chk("single_hold", ram_read_address, 13'h010);

      // RAW hazard on rd1 while rd0 reads elsewhere
      nxt();
      wr_req = 1'b1; wr_addr = 13'h100; wr_data = 8'h15;
      rd1_req = 1'b1; rd1_addr = 13'h100;
      rd0_req = 1'b1; rd0_addr = 13'h050;
      #1;
      chk("raw_wgnt", wr_gnt, 1'b1);
      chk("raw_g1_blocked", rd1_gnt, 1'b0);
      chk("raw_g0", rd0_gnt, 1'b1);
      nxt(); wr_req = 1'b0; rd0_req = 1'b0; #1;
      chk("raw_g1_next", rd1_gnt, 1'b1);
      chk("raw_we", ram_we, 1'b1);
      chk("raw_waddr", ram_write_address, 13'h100);
      chk("raw_wdata", ram_data_In, 8'h15);
      chk("raw_raddr0", ram_read_address, 13'h050);
      nxt(); idle(); #1;
      chk("raw_we_off", ram_we, 1'b0);
      chk("raw_raddr1", ram_read_address, 13'h100);
      chk_rsp("raw_rsp0", 1'b1, 1'b0, 1'b0, 5'h0A);
      nxt(); #1;
      chk_rsp("raw_rsp1", 1'b1, 1'b1, 1'b0, 5'h15);

      // Out-of-range read and write, then last legal address
      nxt();
      rd0_req = 1'b1; rd0_addr = 13'd6613;
      wr_req = 1'b1; wr_addr = 13'd7000; wr_data = 8'h3C;
      #1;
      chk("oor_g0", rd0_gnt, 1'b1);
      chk("oor_wgnt", wr_gnt, 1'b1);
      nxt(); idle(); rd1_req = 1'b1; rd1_addr = 13'd6612; #1;
      chk("oor_we", ram_we, 1'b0);
      chk("oor_raddr_hold", ram_read_address, 13'h100);
      chk("last_g1", rd1_gnt, 1'b1);
      nxt(); idle(); #1;
      chk_rsp("oor_rsp", 1'b1, 1'b0, 1'b1, 5'h0);
      chk("last_raddr", ram_read_address, 13'd6612);
      chk("oor_we2", ram_we, 1'b0);
      nxt(); #1;
      chk_rsp("last_rsp", 1'b1, 1'b1, 1'b0, 5'h0E);

      // Concurrent independent write and read
      nxt();
      wr_req = 1'b1; wr_addr = 13'h020; wr_data = 8'h99;
      rd0_req = 1'b1; rd0_addr = 13'h030;
      #1;
      chk("conc_wgnt", wr_gnt, 1'b1);
      chk("conc_g0", rd0_gnt, 1'b1);
      nxt(); idle(); #1;
      chk("conc_we", ram_we, 1'b1);
      chk("conc_waddr", ram_write_address, 13'h020);
      chk("conc_wdata", ram_data_In, 8'h99);
      chk("conc_raddr", ram_read_address, 13'h030);
      nxt(); #1;
      chk_rsp("conc_rsp", 1'b1, 1'b0, 1'b0, 5'h0A);

      // Reset with two reads in flight
      nxt(); rd0_req = 1'b1; rd0_addr = 13'h011; #1;
      chk("mid_g0", rd0_gnt, 1'b1);
      nxt(); idle(); rd1_req = 1'b1; rd1_addr = 13'h012; Reset_n = 1'b0; #1;
      chk("mid_g1_forced", rd1_gnt, 1'b0);
      nxt(); idle(); Reset_n = 1'b1; #1;
      chk_rsp("mid_rsp_n2", 1'b0, 1'b0, 1'b0, 5'h0);
      chk("mid_raddr", ram_read_address, 13'h0);
      chk("mid_we", ram_we, 1'b0);
      nxt();
      rd0_req = 1'b1; rd0_addr = 13'h011;
      rd1_req = 1'b1; rd1_addr = 13'h012;
      #1;
      chk("mid_rsp_n3", rsp_valid, 1'b0);
      chk("mid_ptr_g0", rd0_gnt, 1'b1);
      chk("mid_ptr_g1", rd1_gnt, 1'b0);
      nxt(); idle(); #1;
      nxt(); #1;
      chk_rsp("mid_new_rsp", 1'b1, 1'b0, 1'b0, 5'h0B);
      nxt(); #1;

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
